// File: rtl/mvm_pkg.sv
// Shared definitions for the mvm_pe instruction sequencer: opcodes, the
// 80-bit layer instruction layout and the sequencer state encodings.
package mvm_pkg;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_MVM_MEM  = 4'h1;
  localparam logic [3:0] OP_MVM_FIFO = 4'h2;
  localparam logic [3:0] OP_SAVE     = 4'h3;
  localparam logic [3:0] OP_END      = 4'hF;

  // Field view of one layer instruction, MSB first.
  typedef struct packed {
    logic [3:0]  op;          // [79:76]
    logic [11:0] rsvd_hi;     // [75:64]
    logic [7:0]  dim_i;       // [63:56]
    logic [7:0]  dim_o;       // [55:48]
    logic [5:0]  rsvd_mid;    // [47:42]
    logic [9:0]  bias_base;   // [41:32]
    logic [3:0]  rsvd_lo;     // [31:28]
    logic [11:0] weight_base; // [27:16]
    logic [15:0] dio_base;    // [15:0]
  } mvm_inst_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

endpackage

// File: rtl/mvm_inst_sched_if.sv
// Instruction-memory read port and PE issue port of the sequencer.
interface mvm_inst_sched_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 80
);
  logic              imem_rd;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_dat;
  logic              pe_valid;
  logic              pe_ready;
  logic [INST_W-1:0] pe_instruction;

  modport master (
    output imem_rd, imem_addr, pe_valid, pe_instruction,
    input  imem_dat, pe_ready
  );

  modport slave (
    input  imem_rd, imem_addr, pe_valid, pe_instruction,
    output imem_dat, pe_ready
  );
endinterface

// File: rtl/mvm_op_decode.sv
// Combinational opcode classifier; exactly one output is high for any opcode.
module mvm_op_decode
  import mvm_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_exec,
  output logic       is_nop,
  output logic       is_end,
  output logic       is_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    is_exec    = 1'b0;
    is_nop     = 1'b0;
    is_end     = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_MVM_MEM, OP_MVM_FIFO, OP_SAVE: is_exec = 1'b1;
      OP_NOP:                           is_nop  = 1'b1;
      OP_END:                           is_end  = 1'b1;
      default:                          is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mvm_inst_sched.sv
// Layer-instruction sequencer: fetches from instruction memory, issues exec
// opcodes to the PE in program order, and reports done/err/count to the host.
module mvm_inst_sched
  import mvm_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int INST_W = 80,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  base_pc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] issued_cnt,
  mvm_inst_sched_if.master bus
);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic            pend;
  logic            is_exec, is_nop, is_end, is_illegal;
  mvm_inst_t       word;

  assign word = mvm_inst_t'(bus.imem_dat);

  mvm_op_decode u_dec (
    .op         (word.op),
    .is_exec    (is_exec),
    .is_nop     (is_nop),
    .is_end     (is_end),
    .is_illegal (is_illegal)
  );

  wire hs      = bus.pe_valid && bus.pe_ready;
  wire pc_last = &pc;

  assign bus.imem_rd   = (state == S_FETCH);
  assign bus.imem_addr = pc;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      pc                 <= '0;
      pend               <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      issued_cnt         <= '0;
      bus.pe_valid       <= 1'b0;
      bus.pe_instruction <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every register sees pre-edge values.
      done <= 1'b0;

      // A PE that accepted but has not yet dropped ready might still be idle-looking.
      if (hs)                 pend <= 1'b1;
      else if (!bus.pe_ready) pend <= 1'b0;

      case (state)
        S_IDLE: begin
          // busy lingers through the done cycle; start is ignored until it clears.
          busy <= 1'b0;
          if (start && !busy) begin
            pc         <= base_pc;
            err        <= 1'b0;
            issued_cnt <= '0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_FETCH: state <= S_WAIT;

        S_WAIT: begin
          if (is_exec) begin
            bus.pe_instruction <= bus.imem_dat;
            bus.pe_valid       <= 1'b1;
            state              <= S_ISSUE;
          end else if (is_nop) begin
            if (pc_last) begin
              err   <= 1'b1;
              state <= pend ? S_DRAIN : S_IDLE;
              busy  <= pend;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end else if (is_end) begin
            state <= S_DRAIN;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_ISSUE: begin
          if (hs) begin
            bus.pe_valid <= 1'b0;
            if (!(&issued_cnt)) issued_cnt <= issued_cnt + 1'b1;
            if (pc_last) begin
              err   <= 1'b1;
              state <= S_DRAIN;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end

        S_DRAIN: begin
          // err here can only come from a pc wrap, which suppresses done.
          if (!pend && bus.pe_ready) begin
            done  <= !err;
            busy  <= !err;
            state <= S_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_inst_sched.sv
// Self-checking bench: program-level reference model vs. per-cycle monitor.
module tb_mvm_inst_sched;
  import mvm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_pc = 8'h00;
  logic       busy, done, err;
  logic [7:0] issued_cnt;

  mvm_inst_sched_if bus ();

  mvm_inst_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_pc    (base_pc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .issued_cnt (issued_cnt),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name,
                       input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory model ----------------
  logic [79:0] mem [256];
  always @(posedge clk) if (bus.imem_rd) bus.imem_dat <= mem[bus.imem_addr];

  function automatic logic [79:0] mk(input logic [3:0] op);
    return {op, 12'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic fill_end();
    for (int i = 0; i < 256; i++) mem[i] = mk(OP_END);
  endtask

  // ---------------- PE model: drops ready for pe_lat cycles per accept ----------------
  logic pe_rdy_r = 1'b1;
  logic pe_block = 1'b0;
  logic pe_noise = 1'b0;
  bit   noise_en = 1'b0;
  int   pe_lat = 1;
  int   pe_cnt = 0;

  assign bus.pe_ready = pe_rdy_r && !pe_block && !pe_noise;

  always @(posedge clk) begin
    pe_noise <= noise_en && ($urandom_range(0, 3) == 0);
    if (bus.pe_valid && bus.pe_ready) begin
      pe_rdy_r <= 1'b0;
      pe_cnt   <= pe_lat;
    end else if (pe_cnt > 1) begin
      pe_cnt <= pe_cnt - 1;
    end else if (pe_cnt == 1) begin
      pe_cnt   <= 0;
      pe_rdy_r <= 1'b1;
    end
  end

  // ---------------- reference model: walk the program ----------------
  logic [79:0] exp_issue[$];
  logic [7:0]  exp_addr[$];
  bit          exp_err, exp_done;

  task automatic build_model(input logic [7:0] base);
    int pc = int'(base);
    bit fin = 1'b0;
    exp_issue.delete();
    exp_addr.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    while (!fin) begin
      logic [3:0] op;
      exp_addr.push_back(8'(pc));
      op = mem[pc][79:76];
      if (op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'h0) begin
        if (op != 4'h0) exp_issue.push_back(mem[pc]);
        if (pc == 255) begin exp_err = 1'b1; fin = 1'b1; end
        else pc++;
      end else if (op == 4'hF) begin
        exp_done = 1'b1; fin = 1'b1;
      end else begin
        exp_err = 1'b1; fin = 1'b1;
      end
    end
  endtask

  // ---------------- per-cycle monitor ----------------
  bit          mon_en = 1'b0;
  int          hs_idx, rd_idx, done_cnt;
  logic        prev_valid = 1'b0, prev_hs = 1'b0;
  logic [79:0] prev_word = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.imem_rd) begin
        if (rd_idx < exp_addr.size())
          check(bus.imem_addr == exp_addr[rd_idx], "imem_addr", bus.imem_addr, exp_addr[rd_idx]);
        else
          check(1'b0, "imem_extra_read", bus.imem_addr, 0);
        rd_idx++;
      end
      if (bus.pe_valid && prev_valid && !prev_hs)
        check(bus.pe_instruction == prev_word, "pe_hold", bus.pe_instruction, prev_word);
      if (bus.pe_valid && bus.pe_ready) begin
        if (hs_idx < exp_issue.size())
          check(bus.pe_instruction == exp_issue[hs_idx], "pe_word", bus.pe_instruction, exp_issue[hs_idx]);
        else
          check(1'b0, "pe_extra_issue", bus.pe_instruction, 0);
        hs_idx++;
      end
      if (done) done_cnt++;
    end
    prev_valid = bus.pe_valid;
    prev_hs    = bus.pe_valid && bus.pe_ready;
    prev_word  = bus.pe_instruction;
  end

  // ---------------- program runner ----------------
  task automatic launch(input logic [7:0] base);
    build_model(base);
    hs_idx = 0; rd_idx = 0; done_cnt = 0;
    mon_en = 1'b1;
    @(negedge clk);
    base_pc = base;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(busy == 1'b1, "busy_rise", busy, 1);
    check(err == 1'b0, "err_clear", err, 0);
  endtask

  task automatic finish_prog(input string tag);
    int n = 0;
    int exp_cnt;
    while (busy === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(n < 20000, {tag, "_timeout"}, n, 20000);
    exp_cnt = (exp_issue.size() > 255) ? 255 : exp_issue.size();
    check(hs_idx == exp_issue.size(), {tag, "_issue_count"}, hs_idx, exp_issue.size());
    check(rd_idx == exp_addr.size(), {tag, "_fetch_count"}, rd_idx, exp_addr.size());
    check(err == exp_err, {tag, "_err"}, err, exp_err);
    check(done_cnt == (exp_done ? 1 : 0), {tag, "_done_count"}, done_cnt, exp_done);
    check(issued_cnt == 8'(exp_cnt), {tag, "_issued_cnt"}, issued_cnt, exp_cnt);
    mon_en = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(done == 1'b0, {tag, "_done"}, done, 0);
    check(err == 1'b0, {tag, "_err"}, err, 0);
    check(issued_cnt == 8'h00, {tag, "_cnt"}, issued_cnt, 0);
    check(bus.imem_rd == 1'b0, {tag, "_imem_rd"}, bus.imem_rd, 0);
    check(bus.imem_addr == 8'h00, {tag, "_imem_addr"}, bus.imem_addr, 0);
    check(bus.pe_valid == 1'b0, {tag, "_pe_valid"}, bus.pe_valid, 0);
    check(bus.pe_instruction == 80'h0, {tag, "_pe_instr"}, bus.pe_instruction, 0);
  endtask

  task automatic set_block(input logic v);
    @(posedge clk);
    #1 pe_block = v;
  endtask

  task automatic load_t2();
    fill_end();
    mem[0] = mk(OP_NOP);
    mem[1] = mk(OP_NOP);
    mem[2] = mk(OP_MVM_FIFO);
    mem[3] = mk(OP_END);
  endtask

  initial begin #5_000_000; $display("FAIL watchdog: simulation time limit"); $fatal(1); end

  initial begin
    logic [79:0] w;
    int          n;

    // Reset state
    fill_end();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Two ops at base 0x10, slow PE
    mem[8'h10] = mk(OP_MVM_MEM);
    mem[8'h11] = mk(OP_SAVE);
    mem[8'h12] = mk(OP_END);
    pe_lat = 20;
    launch(8'h10);
    check(exp_issue.size() == 2, "t1_model_issues", exp_issue.size(), 2);
    finish_prog("t1");
    check(issued_cnt == 8'd2, "t1_cnt_literal", issued_cnt, 2);

    // NOPs then one fifo MVM at base 0
    load_t2();
    pe_lat = 1;
    launch(8'h00);
    check(exp_addr.size() == 4, "t2_model_fetches", exp_addr.size(), 4);
    for (int i = 0; i < 4 && i < exp_addr.size(); i++)
      check(exp_addr[i] == 8'(i), "t2_model_addr", exp_addr[i], i);
    finish_prog("t2");

    // Stall in S_ISSUE for 50 cycles, with an ignored start in the middle
    fill_end();
    w = mk(OP_MVM_MEM);
    mem[0] = w;
    mem[8'h40] = mk(OP_MVM_FIFO);
    set_block(1'b1);
    launch(8'h00);
    n = 0;
    while (!bus.pe_valid && n < 100) begin @(negedge clk); n++; end
    check(bus.pe_valid == 1'b1, "t3_valid_rise", bus.pe_valid, 1);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin base_pc = 8'h40; start = 1'b1; end
      if (i == 21) start = 1'b0;
      check(bus.pe_valid == 1'b1, "t3_valid_held", bus.pe_valid, 1);
      check(bus.pe_instruction == w, "t3_word_held", bus.pe_instruction, w);
      @(negedge clk);
    end
    start = 1'b0;
    set_block(1'b0);
    finish_prog("t3");
    check(issued_cnt == 8'd1, "t3_cnt_literal", issued_cnt, 1);

    // Illegal opcode, then a restart clears err
    fill_end();
    mem[0] = mk(4'h7);
    launch(8'h00);
    finish_prog("t4");
    check(err == 1'b1, "t4_err_literal", err, 1);
    load_t2();
    launch(8'h00);
    finish_prog("t4b");

    // Handshake at pc all-ones: drain, err, no done, no read of 0x00
    fill_end();
    mem[8'hFF] = mk(OP_MVM_MEM);
    mem[8'h00] = mk(OP_MVM_MEM);
    pe_lat = 20;
    launch(8'hFF);
    finish_prog("t5");
    check(done_cnt == 0, "t5_no_done_literal", done_cnt, 0);

    // NOP at pc all-ones
    fill_end();
    mem[8'hFE] = mk(OP_NOP);
    mem[8'hFF] = mk(OP_NOP);
    pe_lat = 1;
    launch(8'hFE);
    finish_prog("t6");

    // 256 issues: counter saturates, then pc wrap error
    for (int i = 0; i < 256; i++) mem[i] = mk(4'($urandom_range(1, 3)));
    launch(8'h00);
    finish_prog("t7");
    check(issued_cnt == 8'hFF, "t7_sat_literal", issued_cnt, 8'hFF);

    // Randomized programs
    for (int t = 0; t < 40; t++) begin
      logic [7:0] b;
      int len;
      fill_end();
      b   = 8'($urandom);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 19);
        logic [3:0] op;
        if (r < 12)      op = 4'($urandom_range(1, 3));
        else if (r < 16) op = OP_NOP;
        else if (r < 18) op = OP_END;
        else             op = 4'($urandom_range(4, 14));
        mem[8'(int'(b) + k)] = mk(op);
      end
      pe_lat   = $urandom_range(1, 6);
      noise_en = $urandom_range(0, 1) == 1;
      launch(b);
      finish_prog("rand");
    end
    noise_en = 1'b0;

    // Reset mid-program
    fill_end();
    mem[0] = mk(OP_MVM_MEM);
    set_block(1'b1);
    launch(8'h00);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    set_block(1'b0);
    repeat (25) @(negedge clk);
    load_t2();
    launch(8'h00);
    finish_prog("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
